// File: rtl/mult_share_pkg.sv
// ---------------------------------------------------------------------------
// mult_share_pkg : shared types for the multiplier scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic id_t;

   // Round-robin pick: a lone requester wins, contention goes to the one
   // that was not granted last.
   function automatic id_t rr_pick(input logic v0, input logic v1, input id_t last);
      id_t w_pick;
      if (v0 && v1) begin
         w_pick = ~last;
      end else if (v1) begin
         w_pick = 1'b1;
      end else begin
         w_pick = 1'b0;
      end
      return w_pick;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_shift_add_core.sv
// ---------------------------------------------------------------------------
// mult_shift_add_core : iterative shift-and-add multiplier, one bit per cycle
// Rev 1.0 ; MULT_EARLY_TERM_EN stops once the remaining multiplier is zero
// ---------------------------------------------------------------------------
`default_nettype none

module mult_shift_add_core #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_done,
   output logic [W-1:0] o_p
);

   localparam int              CNT_W      = $clog2(W + 1);
   localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(W);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [W-1:0]     r_acc;
   logic [W-1:0]     r_a_sh;
   logic [W-1:0]     r_b_sh;
   logic [CNT_W-1:0] r_cnt;
   logic             r_active;
   logic             r_done;

   logic [W-1:0]     w_acc_nxt;
   logic             w_last;

   assign w_acc_nxt = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

`ifdef MULT_EARLY_TERM_EN
   assign w_last = (r_cnt == c_cnt_one) || ((r_b_sh >> 1) == '0);
`else
   assign w_last = (r_cnt == c_cnt_one);
`endif

   // r_done stays set until the next start so the controller can sample it
   // on the cycle after the final step.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc    <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_a_sh   <= i_a;
         r_b_sh   <= i_b;
         r_cnt    <= c_cnt_init;
         r_active <= 1'b1;
         r_done   <= 1'b0;
      end else if (r_active) begin
         r_acc  <= w_acc_nxt;
         r_a_sh <= r_a_sh << 1;
         r_b_sh <= r_b_sh >> 1;
         r_cnt  <= r_cnt - c_cnt_one;
         if (w_last) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
         end
      end
   end

   assign o_done = r_done;
   assign o_p    = r_acc;

endmodule

`default_nettype wire

// File: rtl/mult_share_ctrl.sv
// ---------------------------------------------------------------------------
// mult_share_ctrl : two-requester round-robin scheduler for a shared multiplier
// Rev 1.0 ; MULT_EARLY_TERM_EN (in the core) shortens RUN for small multipliers
// ---------------------------------------------------------------------------
`default_nettype none

module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_p,
   output logic         busy
);

   state_t       r_state;
   state_t       w_state_nxt;
   id_t          r_last_grant;
   id_t          r_cur_id;
   logic         r_rsp_valid;
   id_t          r_rsp_id;
   logic [W-1:0] r_rsp_p;

   id_t          w_gnt_id;
   logic         w_any_req;
   logic         w_accept;
   logic         w_rsp_fire;
   logic         w_core_done;
   logic [W-1:0] w_core_p;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;

   assign w_any_req  = req0_valid | req1_valid;
   assign w_gnt_id   = rr_pick(req0_valid, req1_valid, r_last_grant);
   assign w_a        = w_gnt_id ? req1_a : req0_a;
   assign w_b        = w_gnt_id ? req1_b : req0_b;
   assign w_rsp_fire = (r_state == DONE) && r_rsp_valid && rsp_ready;

   mult_shift_add_core #(
      .W (W)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_accept),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_done  (w_core_done),
      .o_p     (w_core_p)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               req0_ready  = (w_gnt_id == 1'b0);
               req1_ready  = (w_gnt_id == 1'b1);
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_core_done) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // Returning to IDLE here means the next acceptance is a cycle later.
            if (w_rsp_fire) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // rsp_p deliberately survives the response handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_cur_id     <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_p      <= '0;
      end else begin
         if (w_accept) begin
            r_last_grant <= w_gnt_id;
            r_cur_id     <= w_gnt_id;
         end
         if ((r_state == RUN) && w_core_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_cur_id;
            r_rsp_p     <= w_core_p;
         end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_p     = r_rsp_p;
   assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_share_ctrl : directed self-checking bench for mult_share_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mult_share_ctrl;

   localparam int W = 65;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_p;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   mult_share_ctrl #(.W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Edges from the acceptance edge to the edge that raises rsp_valid.
   function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
      int msb = 0;
      for (int k = 0; k < W; k++) if (b[k]) msb = k;
      return msb + 2;
`else
      return W + 1;
`endif
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
   task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_p, input string tag);
      int lat;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      #1;
      check({tag, "_rdy"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
      lat = 0;
      while (!rsp_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         check({tag, "_timeout"}, 1'b0, 1'b1);
      end else begin
         check({tag, "_lat"}, lat, exp_lat(b));
         check({tag, "_p"}, rsp_p, exp_p);
         check({tag, "_id"}, rsp_id, id);
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         check({tag, "_idle"}, {busy, rsp_valid}, 2'b00);
      end
   endtask

   logic [W-1:0] one, hi1, ones, a_v, b_v;
   logic         gnt [4];
   logic         rid [4];
   logic [W-1:0] rp  [4];
   int           gi, ri, lat;
   logic         both_seen;
   int           idx [6] = '{0, 1, 31, 32, 63, 64};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      one  = 1;
      hi1  = {1'b1, 64'd0};
      ones = '1;
      reset = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  busy, 1'b0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_p",     rsp_p, '0);
      check("rst_id",    rsp_id, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_no_req_rdy", {req0_ready, req1_ready}, 2'b00);

      // Continuous contention: requester 0 wins first after reset.
      req0_a = 7;  req0_b = 9;  req1_a = 11; req1_b = 13;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      gi = 0; ri = 0; both_seen = 1'b0;
      for (int c = 0; c < 600 && ri < 4; c++) begin
         #1;
         if (req0_ready && req1_ready) both_seen = 1'b1;
         if (gi < 4 && (req0_ready || req1_ready)) begin
            gnt[gi] = req1_ready;
            gi++;
         end
         if (rsp_valid && ri < 4) begin
            rid[ri] = rsp_id;
            rp[ri]  = rsp_p;
            ri++;
         end
         @(posedge clk);
      end
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      check("rr_grants", gi, 4);
      check("rr_rsps",   ri, 4);
      check("rr_both_rdy", both_seen, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_gnt%0d", k), gnt[k], k[0]);
         check($sformatf("rr_id%0d", k),  rid[k], k[0]);
         check($sformatf("rr_p%0d", k),   rp[k], k[0] ? 143 : 63);
      end
      @(posedge clk); #1;
      check("rr_drained", busy, 1'b0);

      do_op(1'b0, hi1, 1, hi1, "top_bit");
      do_op(1'b1, ones, ones, 1, "all_ones");
      do_op(1'b1, 9, 5, 45, "b5");
      do_op(1'b0, 77, 0, 0, "b0");

      foreach (idx[i]) begin
         foreach (idx[j]) begin
            a_v = one << idx[i];
            b_v = one << idx[j];
            do_op(i[0] ^ j[0], a_v, b_v, a_v * b_v, $sformatf("w1_%0d_%0d", idx[i], idx[j]));
            a_v = ~a_v;
            b_v = ~b_v;
            do_op(i[0] ^ j[0], a_v, b_v, a_v * b_v, $sformatf("w0_%0d_%0d", idx[i], idx[j]));
         end
      end

      // Back-pressure: DONE holds while requester 0 waits.
      req1_valid = 1'b1; req1_a = 5; req1_b = 6;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 2; req0_b = 2;
      lat = 0;
      while (!rsp_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_lat", lat, exp_lat(6));
      for (int k = 0; k < 10; k++) begin
         check("bp_hold", {rsp_valid, rsp_id, rsp_p}, {1'b1, 1'b1, 65'd30});
         check("bp_rdy",  {req0_ready, req1_ready}, 2'b00);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_release", {busy, rsp_valid}, 2'b00);
      check("bp_next_rdy", req0_ready, 1'b1);
      check("bp_p_kept", rsp_p, 30);
      req0_valid = 1'b0;

      // Reset in the middle of an operation.
      req0_valid = 1'b1; req0_a = 123; req0_b = 456;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_busy",  busy, 1'b0);
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_p",     rsp_p, '0);
      check("mid_rst_id",    rsp_id, 1'b0);
      do_op(1'b0, 3, 5, 15, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
